// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and shared-ALU signal bundle for alu_arbiter
interface alu_arbiter_if #(
    parameter int N = 32
);
    logic         req0_valid;
    logic         req0_ready;
    logic [3:0]   req0_op;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         rsp0_valid;
    logic         rsp0_ready;
    logic [N-1:0] rsp0_data;
    logic         rsp0_zero;
    logic         rsp0_overflow;

    logic         req1_valid;
    logic         req1_ready;
    logic [3:0]   req1_op;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [N-1:0] rsp1_data;
    logic         rsp1_zero;
    logic         rsp1_overflow;

    logic [3:0]   alu_op;
    logic [N-1:0] alu_inA;
    logic [N-1:0] alu_inB;
    logic [N-1:0] alu_out;
    logic         alu_zero;
    logic         alu_overflow;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        input  alu_out, alu_zero, alu_overflow,
        output req0_ready, rsp0_valid, rsp0_data, rsp0_zero, rsp0_overflow,
        output req1_ready, rsp1_valid, rsp1_data, rsp1_zero, rsp1_overflow,
        output alu_op, alu_inA, alu_inB
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        output alu_out, alu_zero, alu_overflow,
        input  req0_ready, rsp0_valid, rsp0_data, rsp0_zero, rsp0_overflow,
        input  req1_ready, rsp1_valid, rsp1_data, rsp1_zero, rsp1_overflow,
        input  alu_op, alu_inA, alu_inB
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter for one shared ALU (IDLE/EXEC/RESP)
// ALU_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins); default is round-robin.
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    alu_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_next;
    logic   owner;
    logic   grant_sel;
    logic   handshake;
    logic   rsp_ack;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic   last_grant;
`endif

    // grant_sel names the requester that would win if both contend
    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant_sel = ~bus.req0_valid;
`else
        grant_sel = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
`endif
    end

    always_comb begin
        state_next     = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        handshake      = 1'b0;
        rsp_ack        = owner ? bus.rsp1_ready : bus.rsp0_ready;
        case (state)
            IDLE: begin
                // ready is gated by reset_n so nothing is offered while reset is held
                if (reset_n && (bus.req0_valid || bus.req1_valid)) begin
                    bus.req0_ready = ~grant_sel;
                    bus.req1_ready = grant_sel;
                    handshake      = 1'b1;
                    state_next     = EXEC;
                end
            end
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.rsp0_valid = (state == RESP) && !owner;
    assign bus.rsp1_valid = (state == RESP) && owner;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            owner             <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant        <= 1'b1;
`endif
            bus.alu_op        <= '0;
            bus.alu_inA       <= '0;
            bus.alu_inB       <= '0;
            bus.rsp0_data     <= '0;
            bus.rsp0_zero     <= 1'b0;
            bus.rsp0_overflow <= 1'b0;
            bus.rsp1_data     <= '0;
            bus.rsp1_zero     <= 1'b0;
            bus.rsp1_overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (handshake) begin
                owner       <= grant_sel;
`ifndef ALU_ARB_FIXED_PRIO_EN
                last_grant  <= grant_sel;
`endif
                bus.alu_op  <= grant_sel ? bus.req1_op : bus.req0_op;
                bus.alu_inA <= grant_sel ? bus.req1_a  : bus.req0_a;
                bus.alu_inB <= grant_sel ? bus.req1_b  : bus.req0_b;
            end
            if (state == EXEC) begin
                if (owner) begin
                    bus.rsp1_data     <= bus.alu_out;
                    bus.rsp1_zero     <= bus.alu_zero;
                    bus.rsp1_overflow <= bus.alu_overflow;
                end else begin
                    bus.rsp0_data     <= bus.alu_out;
                    bus.rsp0_zero     <= bus.alu_zero;
                    bus.rsp0_overflow <= bus.alu_overflow;
                end
            end
        end
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, meaning datapath width of operands and result.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports reqK_valid  input  1  requester K (K=0,1) presents an operation.
REQ-005 SHALL have ports reqK_ready  output  1  arbiter accepts requester K this cycle.
REQ-006 SHALL have ports reqK_op  input  4  ALU opcode from constants.vh (ADD, SUB, SLT, ...).
REQ-007 SHALL have ports reqK_a, reqK_b  input  N  operands A and B.
REQ-008 SHALL have ports rspK_valid  output  1  result for requester K available.
REQ-009 SHALL have ports rspK_ready  input  1  requester K consumes the result.
REQ-010 SHALL have ports rspK_data  output  N; rspK_zero, rspK_overflow  output  1 each; registered ALU result and flags.
REQ-011 SHALL have ports alu_op  output  4; alu_inA, alu_inB  output  N; registered drive of the shared ALU.
REQ-012 SHALL have ports alu_out  input  N; alu_zero, alu_overflow  input  1; combinational ALU results.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-014 In IDLE, SHALL assert reqK_ready combinationally for exactly the granted requester with reqK_valid high; never both.
REQ-015 Grant rule: one requester valid -> it wins; both valid -> requester not granted last wins (round-robin); last-grant pointer resets to 1, so req0 wins the first tie.
REQ-016 On handshake (valid & ready) SHALL latch op/a/b into alu_op/alu_inA/alu_inB, record owner, update last-grant pointer, go IDLE->EXEC.
REQ-017 In EXEC (one cycle) SHALL capture alu_out/alu_zero/alu_overflow into owner's rsp registers, go EXEC->RESP.
REQ-018 In RESP SHALL hold rspK_valid high for owner until rspK_ready sampled high, then go RESP->IDLE; rspK_data/flags stable while valid.
REQ-019 Latency: handshake at edge T -> rsp_valid high from edge T+2; minimum issue interval 3 cycles with rsp_ready tied high.
REQ-020 No reqK_ready SHALL be asserted in EXEC or RESP; requests wait, valid may be withdrawn before handshake without effect.
REQ-021 Non-owner rsp_valid SHALL stay 0; rspK_ready from non-owner ignored.
REQ-022 alu_op/alu_inA/alu_inB SHALL hold last value between operations (no toggling in IDLE).
REQ-023 Undefined opcodes SHALL be passed unchanged; arbiter returns whatever the ALU produces (0 for the current ALU).
REQ-024 Widths SHALL be passed through without extension or truncation; flags copied verbatim.

Reset
REQ-025 reset_n low SHALL immediately force: state IDLE, owner 0, last-grant 1, all reqK_ready and rspK_valid 0, rspK_data/flags 0, alu_op/alu_inA/alu_inB 0.
REQ-026 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response delivered after release.
REQ-027 First handshake possible in the first IDLE cycle after reset_n deassertion.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN defined: arbitration SHALL be fixed priority, req0 always wins when both valid; last-grant pointer unused.
REQ-029 Macro undefined: round-robin per REQ-015.

Verification
REQ-030 Reset release, req0 ADD a=5 b=7, rsp0_ready=1 -> req0_ready cycle 0, rsp0_valid at T+2 with data 12, zero 0, overflow 0.
REQ-031 Both valid same cycle repeatedly (req0 SUB 3-3, req1 XOR 0xF0^0x0F) -> grants alternate 0,1,0,1; rsp0 data 0 zero 1; rsp1 data 0xFF; with ALU_ARB_FIXED_PRIO_EN only req0 granted while valid.
REQ-032 req1 SLT a=-1 b=1, rsp1_ready low for 4 cycles -> rsp1_valid held, data 1 stable, req0 ready stays 0 until RESP exits.
REQ-033 reset_n pulsed low during EXEC of req0 ADD 0x7FFFFFFF+1 -> no rsp0_valid afterwards; all outputs 0 during reset.
REQ-034 req0_valid asserted while arbiter in RESP then dropped before IDLE -> no handshake, no ALU input change.
REQ-035 Undefined opcode 4'hF from req0 -> rsp0_data 0, zero 1, overflow 0, FSM returns to IDLE normally.
